// File: rtl/detector_intermitente.sv
// Receive-side monitor for a green/blinking-red lamp pair: synchronizes both lamps, times each
// phase in prescaled ticks, counts red blinks, flags protocol errors and pulses per good cycle.
module detector_intermitente #(
  parameter int unsigned TICK        = 25_000_000,
  parameter int unsigned GREEN_TICKS = 8,
  parameter int unsigned TOL         = 1,
  parameter int unsigned MIN_BLINKS  = 1,
  parameter int unsigned TIMEOUT     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       verde,
  input  logic       vermelho,
  input  logic       clr,
  output logic [1:0] estado,
  output logic       erro,
  output logic       ciclo_ok,
  output logic [7:0] pisca_cnt
);

  localparam int unsigned PW      = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int unsigned GMinI   = (GREEN_TICKS > TOL) ? GREEN_TICKS - TOL : 0;
  localparam int unsigned GMaxI   = (GREEN_TICKS + TOL > 255) ? 255 : GREEN_TICKS + TOL;
  localparam int unsigned TmoI    = (TIMEOUT > 255) ? 255 : TIMEOUT;
  localparam int unsigned MinBlI  = (MIN_BLINKS > 255) ? 255 : MIN_BLINKS;

  localparam logic [PW-1:0] TickMax = PW'(TICK - 1);
  localparam logic [7:0]    GMin    = 8'(GMinI);
  localparam logic [7:0]    GMax    = 8'(GMaxI);
  localparam logic [7:0]    Tmo     = 8'(TmoI);
  localparam logic [7:0]    MinBl   = 8'(MinBlI);

  typedef enum logic [1:0] {
    StOff      = 2'd0,
    StVerde    = 2'd1,
    StVermelho = 2'd2,
    StErro     = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    v_sync_q, r_sync_q;
  logic          v_prev_q, r_prev_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    dur_q, dur_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          erro_q, ok_q, ok_d;
  logic          restart;
  logic [7:0]    cnt_inc, cnt_eff;

  logic v_lvl, r_lvl, v_rise, v_fall, r_rise;
  assign v_lvl  = v_sync_q[1];
  assign r_lvl  = r_sync_q[1];
  assign v_rise = v_lvl & ~v_prev_q;
  assign v_fall = ~v_lvl & v_prev_q;
  assign r_rise = r_lvl & ~r_prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ok_d    = 1'b0;
    restart = 1'b0;
    cnt_inc = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
    cnt_eff = r_rise ? cnt_inc : cnt_q;

    // Lamps both on is always a fault and overrides any edge seen in the same cycle.
    if (state_q != StErro && v_lvl && r_lvl) begin
      state_d = StErro;
    end else begin
      unique case (state_q)
        StOff: begin
          if (v_rise)      state_d = StVerde;
          else if (r_rise) state_d = StErro;
        end
        StVerde: begin
          if (v_fall) begin
            if (dur_q >= GMin && dur_q <= GMax) begin
              state_d = StVermelho;
              cnt_d   = 8'd0;
            end else begin
              state_d = StErro;
            end
          end else if (dur_q > GMax) begin
            state_d = StErro;
          end
        end
        StVermelho: begin
          if (v_rise) begin
            cnt_d = cnt_eff;
            if (cnt_eff >= MinBl) begin
              state_d = StVerde;
              ok_d    = 1'b1;
            end else begin
              state_d = StErro;
            end
          end else if (r_rise) begin
            cnt_d   = cnt_inc;
            restart = 1'b1;
          end else if (dur_q >= Tmo) begin
            state_d = StOff;
          end
        end
        StErro: begin
          if (clr) state_d = StOff;
        end
      endcase
    end

    if (state_d != state_q) restart = 1'b1;

    presc_d = presc_q + PW'(1);
    dur_d   = dur_q;
    if (restart) begin
      presc_d = '0;
      dur_d   = 8'd0;
    end else if (presc_q == TickMax) begin
      presc_d = '0;
      dur_d   = (dur_q == 8'hff) ? dur_q : dur_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StOff;
      v_sync_q <= 2'b00;
      r_sync_q <= 2'b00;
      v_prev_q <= 1'b0;
      r_prev_q <= 1'b0;
      presc_q  <= '0;
      dur_q    <= 8'd0;
      cnt_q    <= 8'd0;
      erro_q   <= 1'b0;
      ok_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      v_sync_q <= {v_sync_q[0], verde};
      r_sync_q <= {r_sync_q[0], vermelho};
      v_prev_q <= v_sync_q[1];
      r_prev_q <= r_sync_q[1];
      presc_q  <= presc_d;
      dur_q    <= dur_d;
      cnt_q    <= cnt_d;
      erro_q   <= (state_d == StErro);
      ok_q     <= ok_d;
    end
  end

  assign estado    = state_q;
  assign erro      = erro_q;
  assign ciclo_ok  = ok_q;
  assign pisca_cnt = cnt_q;

endmodule

// File: tb/tb_detector_intermitente.sv
// Bench for detector_intermitente: directed scenarios plus random lamp traffic, all checked
// every cycle against a clock-count based reference model.
module tb_detector_intermitente;

  localparam int TICK = 4;
  localparam int GT   = 8;
  localparam int TOL  = 1;
  localparam int MINB = 1;
  localparam int TOUT = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       verde = 1'b0;
  logic       vermelho = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] estado;
  logic       erro;
  logic       ciclo_ok;
  logic [7:0] pisca_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  detector_intermitente #(
    .TICK       (TICK),
    .GREEN_TICKS(GT),
    .TOL        (TOL),
    .MIN_BLINKS (MINB),
    .TIMEOUT    (TOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .verde    (verde),
    .vermelho (vermelho),
    .clr      (clr),
    .estado   (estado),
    .erro     (erro),
    .ciclo_ok (ciclo_ok),
    .pisca_cnt(pisca_cnt)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: state 0..3, clocks since last phase restart, blink count.
  int m_st, m_n, m_cnt, m_ok;
  bit vq[$];
  bit rq[$];

  task automatic model_reset();
    m_st = 0; m_n = 0; m_cnt = 0; m_ok = 0;
    vq.delete(); rq.delete();
    for (int i = 0; i < 4; i++) begin
      vq.push_back(1'b0);
      rq.push_back(1'b0);
    end
  endtask

  task automatic model_step();
    bit vl, vp, rl, rp, vrise, vfall, rrise, restart;
    int dur, ns, c;
    vq.push_front(verde);    void'(vq.pop_back());
    rq.push_front(vermelho); void'(rq.pop_back());
    // Lamp levels seen by the decision logic lag the pins by two samples.
    vl = vq[2]; vp = vq[3]; rl = rq[2]; rp = rq[3];
    vrise = vl && !vp; vfall = !vl && vp; rrise = rl && !rp;
    dur = m_n / TICK;
    if (dur > 255) dur = 255;
    ns = m_st; m_ok = 0; restart = 0;
    if (m_st != 3 && vl && rl) ns = 3;
    else begin
      case (m_st)
        0: if (vrise) ns = 1; else if (rrise) ns = 3;
        1: begin
          if (vfall) begin
            if (dur >= GT - TOL && dur <= GT + TOL) begin ns = 2; m_cnt = 0; end
            else ns = 3;
          end else if (dur > GT + TOL) ns = 3;
        end
        2: begin
          c = m_cnt + (rrise ? 1 : 0);
          if (c > 255) c = 255;
          if (vrise) begin
            m_cnt = c;
            if (c >= MINB) begin ns = 1; m_ok = 1; end
            else ns = 3;
          end else if (rrise) begin
            m_cnt = c; restart = 1;
          end else if (dur >= TOUT) ns = 0;
        end
        default: if (clr) ns = 0;
      endcase
    end
    if (ns != m_st || restart) m_n = 0;
    else if (m_n < 100000) m_n++;
    m_st = ns;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check_eq("estado", int'(estado), m_st);
        check_eq("erro", int'(erro), (m_st == 3) ? 1 : 0);
        check_eq("ciclo_ok", int'(ciclo_ok), m_ok);
        check_eq("pisca_cnt", int'(pisca_cnt), m_cnt);
      end
    end
  end

  task automatic drive(input bit v, input bit r, input int cycles);
    verde = v;
    vermelho = r;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    int gl, np;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 4);
    check_eq("post_reset_estado", int'(estado), 0);

    // Nominal cycle with four blinks.
    drive(1, 0, 32);
    drive(0, 0, 4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 8);
      drive(0, 0, 8);
    end
    drive(1, 0, 6);
    check_eq("nominal_cnt", int'(pisca_cnt), 4);
    check_eq("nominal_estado", int'(estado), 1);

    // Back into red, three blinks, then asynchronous reset between clock edges.
    drive(1, 0, 26);
    drive(0, 0, 4);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 6);
      drive(0, 0, 6);
    end
    check_eq("pre_reset_cnt", int'(pisca_cnt), 3);
    check_eq("pre_reset_estado", int'(estado), 2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_estado", int'(estado), 0);
    check_eq("rst_erro", int'(erro), 0);
    check_eq("rst_ciclo_ok", int'(ciclo_ok), 0);
    check_eq("rst_cnt", int'(pisca_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 6);
    check_eq("idle_after_reset", int'(estado), 0);

    // Short green.
    drive(1, 0, 20);
    drive(0, 0, 6);
    check_eq("short_estado", int'(estado), 3);
    check_eq("short_erro", int'(erro), 1);
    pulse_clr();
    drive(0, 0, 2);
    check_eq("clr_estado", int'(estado), 0);
    check_eq("clr_erro", int'(erro), 0);

    // Overlap during green, then lamps dropped.
    drive(1, 0, 12);
    drive(1, 1, 4);
    check_eq("overlap_estado", int'(estado), 3);
    drive(0, 0, 20);
    check_eq("overlap_hold", int'(estado), 3);
    pulse_clr();

    // Source switched off after a valid green.
    drive(1, 0, 32);
    drive(0, 0, 40);
    check_eq("srcoff_estado", int'(estado), 0);
    check_eq("srcoff_erro", int'(erro), 0);

    // Red first, then green length boundaries.
    drive(0, 1, 4);
    drive(0, 0, 4);
    check_eq("redfirst_estado", int'(estado), 3);
    pulse_clr();
    drive(0, 0, 3);
    drive(1, 0, 36);
    drive(0, 0, 6);
    check_eq("green9_estado", int'(estado), 2);
    drive(0, 1, 4);
    drive(0, 0, 4);
    drive(1, 0, 44);
    check_eq("green10_estado", int'(estado), 3);
    drive(0, 0, 4);
    pulse_clr();
    drive(0, 0, 4);

    // Random traffic: mostly plausible cycles with occasional faults, timeouts and clears.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) pulse_clr();
      gl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 24)) : int'($urandom_range(28, 44));
      if ($urandom_range(0, 9) == 0) begin
        drive(1, 0, gl / 2);
        drive(1, 1, int'($urandom_range(1, 5)));
        drive(1, 0, gl / 2);
      end else begin
        drive(1, 0, gl);
      end
      drive(0, 0, int'($urandom_range(1, 10)));
      np = int'($urandom_range(0, 5));
      for (int p = 0; p < np; p++) begin
        drive(0, 1, int'($urandom_range(1, 10)));
        drive(0, 0, ($urandom_range(0, 7) == 0) ? int'($urandom_range(30, 45))
                                               : int'($urandom_range(1, 12)));
      end
    end
    drive(0, 0, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
